// File: rtl/reg_ctx_if.sv
// Bus bundle between the core side and the register-context engine:
// request/base inputs, register-file ports and data-memory ports.
interface reg_ctx_if #(
    parameter int W  = 8,
    parameter int A  = 2,
    parameter int MA = 8
);
    logic          save_req;
    logic          restore_req;
    logic [MA-1:0] base_addr;
    logic          busy;
    logic          done;
    logic [A-1:0]  rf_raddr;
    logic [W-1:0]  rf_rdata;
    logic [A-1:0]  rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic          rf_we;
    logic [MA-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_we;

    modport master (
        output save_req, restore_req, base_addr, rf_rdata, mem_rdata,
        input  busy, done, rf_raddr, rf_waddr, rf_wdata, rf_we,
               mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  save_req, restore_req, base_addr, rf_rdata, mem_rdata,
        output busy, done, rf_raddr, rf_waddr, rf_wdata, rf_we,
               mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/reg_ctx_engine.sv
// Context save/restore engine: streams every register to a memory frame
// (save) or from a memory frame back into the register file (restore).
module reg_ctx_engine #(
    parameter int W  = 8,
    parameter int A  = 2,
    parameter int MA = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    reg_ctx_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    localparam logic [A-1:0] IDX_LAST = '1;

    state_t        r_state;
    logic [A-1:0]  r_idx;
    logic [MA-1:0] r_base;

    state_t        w_state_nxt;
    logic [A-1:0]  w_idx_nxt;
    logic [MA-1:0] w_base_nxt;
    logic [MA-1:0] w_frame_addr;

    assign w_frame_addr = r_base + MA'(r_idx);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_base  <= w_base_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_base_nxt    = r_base;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.rf_raddr  = '0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.rf_we     = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        case (r_state)
            IDLE: begin
                // Save has priority; a simultaneous restore is dropped.
                if (bus.save_req || bus.restore_req) begin
                    w_state_nxt = bus.save_req ? SAVE : RESTORE;
                    w_idx_nxt   = '0;
                    w_base_nxt  = bus.base_addr;
                end
            end
            SAVE: begin
                bus.busy      = 1'b1;
                bus.rf_raddr  = r_idx;
                bus.mem_addr  = w_frame_addr;
                bus.mem_wdata = bus.rf_rdata;
                bus.mem_we    = 1'b1;
                w_idx_nxt     = r_idx + 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = DONE;
                    w_idx_nxt   = '0;
                end
            end
            RESTORE: begin
                bus.busy     = 1'b1;
                bus.mem_addr = w_frame_addr;
                bus.rf_waddr = r_idx;
                bus.rf_wdata = bus.mem_rdata;
                bus.rf_we    = 1'b1;
                w_idx_nxt    = r_idx + 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = DONE;
                    w_idx_nxt   = '0;
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine: register-file and memory models,
// write scoreboard queue, immediate-assertion checks.
module tb_reg_ctx_engine;
    typedef struct packed {
        logic       is_mem;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   mem_wr_cnt;
    logic [7:0] regs [4];
    logic [7:0] mem  [256];
    wr_t  exp_q [$];

    always #5 clk = ~clk;

    reg_ctx_if #(.W(8), .A(2), .MA(8)) bus ();
    reg_ctx_engine #(.W(8), .A(2), .MA(8)) dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

    assign bus.rf_rdata  = regs[bus.rf_raddr];
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.rf_we)  regs[bus.rf_waddr] <= bus.rf_wdata;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge, check status, score any write.
    task automatic mon(input logic eb, input logic ed, input logic emw, input logic erw);
        wr_t e;
        @(negedge clk);
        check("busy", {7'd0, bus.busy}, {7'd0, eb});
        check("done", {7'd0, bus.done}, {7'd0, ed});
        check("mem_we", {7'd0, bus.mem_we}, {7'd0, emw});
        check("rf_we", {7'd0, bus.rf_we}, {7'd0, erw});
        if (bus.mem_we === 1'b1 || bus.rf_we === 1'b1) begin
            if (bus.mem_we === 1'b1) mem_wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 8'h01, 8'h00);
            end else begin
                e = exp_q.pop_front();
                check("wr_kind", {7'd0, bus.mem_we}, {7'd0, e.is_mem});
                if (e.is_mem) begin
                    check("mem_addr", bus.mem_addr, e.addr);
                    check("mem_wdata", bus.mem_wdata, e.data);
                    check("rf_waddr_idle", {6'd0, bus.rf_waddr}, 8'h00);
                end else begin
                    check("rf_waddr", {6'd0, bus.rf_waddr}, e.addr);
                    check("rf_wdata", bus.rf_wdata, e.data);
                    check("mem_wdata_idle", bus.mem_wdata, 8'h00);
                end
            end
        end
    endtask

    // Drive a request for one edge, then scramble BaseAddr.
    task automatic req(input logic s, input logic r, input logic [7:0] base);
        bus.save_req    = s;
        bus.restore_req = r;
        bus.base_addr   = base;
        @(posedge clk);
        #1;
        bus.save_req    = 1'b0;
        bus.restore_req = 1'b0;
        bus.base_addr   = 8'h5A;
    endtask

    task automatic push_save(input logic [7:0] base, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        exp_q.push_back('{1'b1, base,        d0});
        exp_q.push_back('{1'b1, base + 8'd1, d1});
        exp_q.push_back('{1'b1, base + 8'd2, d2});
        exp_q.push_back('{1'b1, base + 8'd3, d3});
    endtask

    task automatic full_op(input logic is_save);
        for (int i = 0; i < 4; i++) mon(1'b1, 1'b0, is_save, !is_save);
        mon(1'b0, 1'b1, 1'b0, 1'b0);
        mon(1'b0, 1'b0, 1'b0, 1'b0);
        check("queue_drained", 8'(exp_q.size()), 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
        bus.save_req = 1'b0; bus.restore_req = 1'b0; bus.base_addr = 8'h00;
        mem_wr_cnt = 0;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_mem_addr", bus.mem_addr, 8'h00);
        check("rst_rf_raddr", {6'd0, bus.rf_raddr}, 8'h00);
        check("rst_rf_wdata", bus.rf_wdata, 8'h00);
        check("rst_mem_wdata", bus.mem_wdata, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) mon(1'b0, 1'b0, 1'b0, 1'b0);

        // Save 0x11..0x44 to 0x40
        push_save(8'h40, 8'h11, 8'h22, 8'h33, 8'h44);
        req(1'b1, 1'b0, 8'h40);
        full_op(1'b1);
        check("mem40", mem[8'h40], 8'h11);
        check("mem41", mem[8'h41], 8'h22);
        check("mem42", mem[8'h42], 8'h33);
        check("mem43", mem[8'h43], 8'h44);

        // Restore from 0x80
        mem[8'h80] = 8'hA0; mem[8'h81] = 8'hB1; mem[8'h82] = 8'hC2; mem[8'h83] = 8'hD3;
        exp_q.push_back('{1'b0, 8'd0, 8'hA0});
        exp_q.push_back('{1'b0, 8'd1, 8'hB1});
        exp_q.push_back('{1'b0, 8'd2, 8'hC2});
        exp_q.push_back('{1'b0, 8'd3, 8'hD3});
        req(1'b0, 1'b1, 8'h80);
        full_op(1'b0);
        check("reg0", regs[0], 8'hA0);
        check("reg1", regs[1], 8'hB1);
        check("reg2", regs[2], 8'hC2);
        check("reg3", regs[3], 8'hD3);

        // Address wrap at 0xFE
        exp_q.push_back('{1'b1, 8'hFE, 8'hA0});
        exp_q.push_back('{1'b1, 8'hFF, 8'hB1});
        exp_q.push_back('{1'b1, 8'h00, 8'hC2});
        exp_q.push_back('{1'b1, 8'h01, 8'hD3});
        req(1'b1, 1'b0, 8'hFE);
        full_op(1'b1);

        // Both requests: save wins; a re-request during SAVE is ignored
        push_save(8'h60, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
        mem_wr_cnt = 0;
        req(1'b1, 1'b1, 8'h60);
        mon(1'b1, 1'b0, 1'b1, 1'b0);
        bus.save_req = 1'b1;
        mon(1'b1, 1'b0, 1'b1, 1'b0);
        bus.save_req = 1'b0;
        mon(1'b1, 1'b0, 1'b1, 1'b0);
        mon(1'b1, 1'b0, 1'b1, 1'b0);
        mon(1'b0, 1'b1, 1'b0, 1'b0);
        mon(1'b0, 1'b0, 1'b0, 1'b0);
        mon(1'b0, 1'b0, 1'b0, 1'b0);
        check("mem_wr_count", 8'(mem_wr_cnt), 8'd4);
        check("queue_drained_both", 8'(exp_q.size()), 8'h00);

        // Reset in the second SAVE cycle
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 8'h00;
        push_save(8'h40, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
        req(1'b1, 1'b0, 8'h40);
        mon(1'b1, 1'b0, 1'b1, 1'b0);
        mon(1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        mon(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) mon(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_mem40", mem[8'h40], 8'hA0);
        check("abort_mem41", mem[8'h41], 8'hB1);
        check("abort_mem42", mem[8'h42], 8'h00);
        check("abort_mem43", mem[8'h43], 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_ctx_engine.md
Name: reg_ctx_engine

Overview:
- Context save/restore engine for the 4-entry, 8-bit register file.
- Reads every register through the register-file read port and writes it to data memory (save), or reads data memory and writes it back through the register-file write port (restore).
- Sits beside the core's register file and data memory. Asserts Busy so the core stalls its own register and memory traffic during a transfer.
- Used for call/interrupt context switches.

Parameters:
- W, 8, data path width.
- A, 2, register address width; NREG = 2**A registers are transferred.
- MA, 8, data memory address width.

Ports:
- Clk  input  1  clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-low reset (Reset==0 at a rising edge of Clk resets the block).
- SaveReq  input  1  start save; sampled only in IDLE.
- RestoreReq  input  1  start restore; sampled only in IDLE.
- BaseAddr  input  MA  memory base address of the context frame; latched on request acceptance.
- Busy  output  1  high in SAVE and RESTORE states.
- Done  output  1  one-cycle pulse after the last transfer.
- RfRaddr  output  A  register-file read address (feeds the register file's combinational read).
- RfRdata  input  W  register-file read data, combinational from RfRaddr.
- RfWaddr  output  A  register-file write address.
- RfWdata  output  W  register-file write data.
- RfWriteEn  output  1  register-file write enable.
- MemAddr  output  MA  data memory address.
- MemWdata  output  W  data memory write data.
- MemRdata  input  W  data memory read data, combinational from MemAddr.
- MemWriteEn  output  1  data memory write enable.

Behaviour:
- State register: IDLE, SAVE, RESTORE, DONE. Index counter idx (A bits). Latched base register base_q (MA bits).
- Reset (Reset==0 at a clock edge): state=IDLE, idx=0, base_q=0.
  - All outputs are combinational from registered state, so after reset: Busy=0, Done=0, RfWriteEn=0, MemWriteEn=0, RfRaddr=0, RfWaddr=0, MemAddr=0, RfWdata=0, MemWdata=0.
  - Reset mid-transfer aborts immediately. No write enable is asserted in the cycle after the reset edge. Already-written locations stay written; no rollback.
- IDLE: all enables low, address/data outputs 0.
  - SaveReq=1 at an edge -> SAVE, idx=0, base_q=BaseAddr.
  - Else RestoreReq=1 -> RESTORE, same latching.
  - Both high: save wins; the restore is dropped, not queued.
- SAVE (Busy=1), one register per cycle:
  - RfRaddr=idx, MemAddr=base_q+idx, MemWdata=RfRdata, MemWriteEn=1.
  - idx increments each edge. At idx==NREG-1 the next state is DONE and idx goes to 0.
- RESTORE (Busy=1), one register per cycle:
  - MemAddr=base_q+idx, RfWaddr=idx, RfWdata=MemRdata, RfWriteEn=1.
  - Same counting and exit as SAVE.
- DONE: Done=1 for exactly one cycle, Busy=0, enables low; the next state is IDLE unconditionally.
- Requests:
  - Requests in SAVE, RESTORE or DONE are ignored, not queued.
  - A request held high through DONE is accepted on the first IDLE edge.
- Latency: request edge N -> transfers in cycles N+1..N+NREG -> Done in cycle N+NREG+1 -> back in IDLE at N+NREG+2. Back-to-back operations start no sooner than 2 cycles after the last transfer.
- Arithmetic:
  - MemAddr = base_q + zero-extended idx, truncated to MA bits, so wrap is modulo 2**MA (base 0xFE gives 0xFE, 0xFF, 0x00, 0x01).
  - BaseAddr changes after acceptance have no effect.
- SAVE never asserts RfWriteEn; RESTORE never asserts MemWriteEn. RfWaddr/RfWdata are 0 outside RESTORE; MemWdata is 0 outside SAVE.

Test Plan:
- Reset, then idle 3 cycles -> Busy=0, Done=0, both write enables 0 every cycle.
- Regs={0x11,0x22,0x33,0x44}, BaseAddr=0x40, SaveReq pulse -> 4 cycles with MemWriteEn=1 at 0x40..0x43 carrying 0x11..0x44. Done pulses in cycle 5; mem[0x40..0x43]={0x11,0x22,0x33,0x44}.
- mem[0x80..0x83]={0xA0,0xB1,0xC2,0xD3}, RestoreReq at base 0x80 -> RfWriteEn=1 for 4 cycles with RfWaddr 0..3 and data 0xA0..0xD3. The register file then holds those values; MemWriteEn is never 1.
- BaseAddr=0xFE save -> MemAddr sequence 0xFE, 0xFF, 0x00, 0x01.
- SaveReq and RestoreReq high together -> save performed; no RfWriteEn. A second SaveReq asserted during SAVE is ignored; exactly 4 memory writes occur.
- Reset driven low in the 2nd SAVE cycle -> only 0x40 (and 0x41 if written at that edge) are modified. Next cycle: Busy=0, no enables, Done never pulses.
